operand_memory: RTL and testbench

Parametrised operand store for the systolic convolution array. It holds one IMG_N×IMG_N input image and one KER_N×KER_N filter kernel. Both are loaded through a streaming valid/ready port rather than wide parallel inputs. NUM_RD independent registered read ports serve the PE-feeding logic, and a load controller tracks when both operands are resident.

---
 rtl/operand_memory_pkg.sv | 38 +++
 rtl/operand_read_port.sv | 63 ++++++
 rtl/operand_memory.sv | 142 ++++++++++++++
 tb/tb_operand_memory.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_memory_pkg.sv
// Shared types and helpers for the operand store: state encoding, bank
// select values and the address split used by every read port.
package operand_memory_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } ld_state_e;

  localparam logic BANK_IMG = 1'b0;
  localparam logic BANK_KER = 1'b1;

  typedef struct packed {
    logic        bank;
    logic [30:0] index;
  } addr_split_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // The top address bit picks the bank; the remaining bits are row*IMG_N+col.
  function automatic addr_split_t addr_split(input logic [31:0] addr, input int addr_w);
    addr_split_t s;
    s.bank  = addr[5'(addr_w - 1)];
    s.index = 31'(addr & ((32'd1 << (addr_w - 1)) - 32'd1));
    return s;
  endfunction

endpackage

// File: rtl/operand_read_port.sv
// One registered read port: decodes bank/index, zero-fills locations outside
// the stored image or kernel, and holds its data when not enabled.
module operand_read_port
  import operand_memory_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_N  = 4,
  parameter int KER_N  = 3,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] img_mem_i [IMG_N*IMG_N],
  input  logic [DATA_W-1:0] ker_mem_i [KER_N*KER_N],
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  localparam int IMG_WORDS = IMG_N * IMG_N;
  localparam int KER_WORDS = KER_N * KER_N;
  localparam int IMG_AW    = clog2(IMG_WORDS);
  localparam int KER_AW    = (KER_WORDS > 1) ? clog2(KER_WORDS) : 1;

  addr_split_t       split;
  int unsigned       ker_row;
  int unsigned       ker_col;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  // The kernel shares the image stride, so its row/col come from IMG_N.
  always_comb begin
    split   = addr_split(32'(rd_addr_i), ADDR_W);
    ker_row = 32'(split.index) / IMG_N;
    ker_col = 32'(split.index) % IMG_N;
    word    = '0;
    if (split.bank == BANK_IMG) begin
      if (32'(split.index) < IMG_WORDS) begin
        word = img_mem_i[IMG_AW'(split.index)];
      end
    end else if (ker_row < KER_N && ker_col < KER_N) begin
      word = ker_mem_i[KER_AW'(ker_row * KER_N + ker_col)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_en_i;
      if (rd_en_i) begin
        data_q <= word;
      end
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;

endmodule

// File: rtl/operand_memory.sv
// Image + kernel operand store with a streaming loader and NUM_RD
// independent registered read ports.
module operand_memory
  import operand_memory_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int IMG_N  = 4,
  parameter  int KER_N  = 3,
  parameter  int NUM_RD = 3,
  localparam int ADDR_W = 1 + clog2(IMG_N * IMG_N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_start,
  input  logic                     ld_sel,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     ld_done,
  output logic                     img_loaded,
  output logic                     ker_loaded,
  output logic                     operands_ready,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

  localparam int IMG_WORDS = IMG_N * IMG_N;
  localparam int KER_WORDS = KER_N * KER_N;
  localparam int IMG_AW    = clog2(IMG_WORDS);
  localparam int KER_AW    = (KER_WORDS > 1) ? clog2(KER_WORDS) : 1;
  localparam int RC_W      = clog2(IMG_N);

  ld_state_e         state_q;
  logic              sel_q;
  logic [RC_W-1:0]   row_q;
  logic [RC_W-1:0]   col_q;
  logic              ld_ready_q;
  logic              ld_done_q;
  logic              img_loaded_q;
  logic              ker_loaded_q;
  logic [DATA_W-1:0] img_mem_q [IMG_WORDS];
  logic [DATA_W-1:0] ker_mem_q [KER_WORDS];

  int unsigned width_d;
  int unsigned wr_idx_d;
  logic        last_col_d;
  logic        last_row_d;
  logic        beat_d;

  // Write pointer uses the loading bank's own width, so kernel words pack densely.
  always_comb begin
    width_d    = (sel_q == BANK_KER) ? 32'(KER_N) : 32'(IMG_N);
    last_col_d = (32'(col_q) == width_d - 1);
    last_row_d = (32'(row_q) == width_d - 1);
    beat_d     = (state_q == ST_LOAD) && ld_valid;
    wr_idx_d   = 32'(row_q) * width_d + 32'(col_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= BANK_IMG;
      row_q        <= '0;
      col_q        <= '0;
      ld_ready_q   <= 1'b0;
      ld_done_q    <= 1'b0;
      img_loaded_q <= 1'b0;
      ker_loaded_q <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ld_start) begin
            state_q    <= ST_LOAD;
            sel_q      <= ld_sel;
            row_q      <= '0;
            col_q      <= '0;
            ld_ready_q <= 1'b1;
            if (ld_sel == BANK_KER) ker_loaded_q <= 1'b0;
            else                    img_loaded_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            if (last_col_d) begin
              col_q <= '0;
              if (last_row_d) begin
                state_q    <= ST_IDLE;
                row_q      <= '0;
                ld_ready_q <= 1'b0;
                ld_done_q  <= 1'b1;
                if (sel_q == BANK_KER) ker_loaded_q <= 1'b1;
                else                   img_loaded_q <= 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IMG_WORDS; i++) img_mem_q[IMG_AW'(i)] <= '0;
      for (int i = 0; i < KER_WORDS; i++) ker_mem_q[KER_AW'(i)] <= '0;
    end else if (beat_d) begin
      if (sel_q == BANK_KER) ker_mem_q[KER_AW'(wr_idx_d)] <= ld_data;
      else                   img_mem_q[IMG_AW'(wr_idx_d)] <= ld_data;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    operand_read_port #(
      .DATA_W (DATA_W),
      .IMG_N  (IMG_N),
      .KER_N  (KER_N),
      .ADDR_W (ADDR_W)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .img_mem_i  (img_mem_q),
      .ker_mem_i  (ker_mem_q),
      .rd_en_i    (rd_en[gi]),
      .rd_addr_i  (rd_addr[gi*ADDR_W +: ADDR_W]),
      .rd_data_o  (rd_data[gi*DATA_W +: DATA_W]),
      .rd_valid_o (rd_valid[gi])
    );
  end

  assign ld_ready       = ld_ready_q;
  assign ld_done        = ld_done_q;
  assign img_loaded     = img_loaded_q;
  assign ker_loaded     = ker_loaded_q;
  assign operands_ready = img_loaded_q & ker_loaded_q;

endmodule

// File: tb/tb_operand_memory.sv
// Randomized bench for operand_memory: a default instance plus a
// parameter-sweep instance, both checked against array-based models.
module tb_operand_memory;

  localparam int DW = 8,  N = 4, K = 3, NR = 3, AW = 5;
  localparam int B_DW = 16, B_N = 5, B_K = 2, B_AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic             rst, ld_start, ld_sel, ld_valid, ld_ready, ld_done;
  logic [DW-1:0]    ld_data;
  logic             img_loaded, ker_loaded, operands_ready;
  logic [NR-1:0]    rd_en, rd_valid;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;

  // Sweep instance
  logic             b_rst, b_ld_start, b_ld_sel, b_ld_valid, b_ld_ready, b_ld_done;
  logic [B_DW-1:0]  b_ld_data;
  logic             b_img_loaded, b_ker_loaded, b_operands_ready;
  logic [0:0]       b_rd_en, b_rd_valid;
  logic [B_AW-1:0]  b_rd_addr;
  logic [B_DW-1:0]  b_rd_data;

  operand_memory #(.DATA_W(DW), .IMG_N(N), .KER_N(K), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_sel(ld_sel), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .ld_done(ld_done), .img_loaded(img_loaded),
    .ker_loaded(ker_loaded), .operands_ready(operands_ready), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  operand_memory #(.DATA_W(B_DW), .IMG_N(B_N), .KER_N(B_K), .NUM_RD(1)) dut_b (
    .clk(clk), .rst(b_rst), .ld_start(b_ld_start), .ld_sel(b_ld_sel), .ld_valid(b_ld_valid),
    .ld_ready(b_ld_ready), .ld_data(b_ld_data), .ld_done(b_ld_done), .img_loaded(b_img_loaded),
    .ker_loaded(b_ker_loaded), .operands_ready(b_operands_ready), .rd_en(b_rd_en),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  // Reference models: image as a flat raster, kernel as a true 2-D array.
  logic [DW-1:0]   img_m [N*N];
  logic [DW-1:0]   ker_m [K][K];
  bit              img_f, ker_f;
  logic [DW-1:0]   last_rd [NR];
  logic [B_DW-1:0] b_img_m [B_N*B_N];
  logic [B_DW-1:0] b_ker_m [B_K][B_K];
  bit              b_img_f, b_ker_f;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N*N; i++) img_m[i] = '0;
    for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) ker_m[r][c] = '0;
    for (int i = 0; i < NR; i++) last_rd[i] = '0;
    img_f = 0;
    ker_f = 0;
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] addr);
    int idx, r, c;
    idx = int'(addr) % (1 << (AW-1));
    r = idx / N;
    c = idx % N;
    if (addr >= AW'(1 << (AW-1))) return (r < K && c < K) ? ker_m[r][c] : '0;
    return (idx < N*N) ? img_m[idx] : '0;
  endfunction

  function automatic logic [B_DW-1:0] b_model_rd(input logic [B_AW-1:0] addr);
    int idx, r, c;
    idx = int'(addr) % (1 << (B_AW-1));
    r = idx / B_N;
    c = idx % B_N;
    if (addr >= B_AW'(1 << (B_AW-1))) return (r < B_K && c < B_K) ? b_ker_m[r][c] : '0;
    return (idx < B_N*B_N) ? b_img_m[idx] : '0;
  endfunction

  task automatic do_reads(input logic [NR-1:0] en, input logic [AW-1:0] a0,
                          input logic [AW-1:0] a1, input logic [AW-1:0] a2, input string tag);
    logic [AW-1:0] a [NR];
    logic [DW-1:0] exp [NR];
    a[0] = a0; a[1] = a1; a[2] = a2;
    rd_en = en;
    for (int i = 0; i < NR; i++) begin
      rd_addr[i*AW +: AW] = a[i];
      exp[i] = en[i] ? model_rd(a[i]) : last_rd[i];
    end
    tick();
    rd_en = '0;
    $display("[TB] read %s en=%b addr=%h,%h,%h data=%h", tag, en, a0, a1, a2, rd_data);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s rd_data[%0d] @%h", tag, i, a[i]), rd_data[i*DW +: DW], exp[i]);
      check($sformatf("%s rd_valid[%0d]", tag, i), rd_valid[i], en[i]);
      last_rd[i] = exp[i];
    end
  endtask

  task automatic random_reads(input int count, input string tag);
    for (int n = 0; n < count; n++)
      do_reads(NR'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), tag);
  endtask

  // gap: 0 none, 1 random, 3 every third cycle. rdw: port 0 reads the word
  // being written. abort_after: assert rst once that many beats are accepted.
  task automatic do_load(input bit sel, input bit seq, input int base, input int gap,
                         input bit rdw, input bit poke_start, input int abort_after,
                         input string tag);
    int total, w, acc, cyc;
    logic [DW-1:0] d;
    logic [AW-1:0] rdw_addr;
    logic [DW-1:0] rdw_exp;
    w = sel ? K : N;
    total = w * w;
    acc = 0;
    cyc = 0;
    ld_start = 1'b1;
    ld_sel = sel;
    tick();
    ld_start = 1'b0;
    check({tag, " ld_ready after start"}, ld_ready, 1);
    check({tag, " ld_done after start"}, ld_done, 0);
    check({tag, " flag cleared"}, sel ? ker_loaded : img_loaded, 0);
    if (sel) ker_f = 0; else img_f = 0;
    while (acc < total) begin
      if (cyc > 400) begin
        check({tag, " load timeout beats"}, acc, total);
        return;
      end
      cyc++;
      if (gap == 3)      ld_valid = (cyc % 3 != 0);
      else if (gap == 1) ld_valid = ($urandom_range(0, 3) != 0);
      else               ld_valid = 1'b1;
      d = seq ? DW'(base + acc) : DW'($urandom);
      ld_data = d;
      ld_start = poke_start && (acc == 2);
      ld_sel = poke_start ? ~sel : sel;
      rdw_addr = '0;
      rdw_exp = '0;
      if (rdw) begin
        rdw_addr = sel ? AW'((1 << (AW-1)) + (acc / w) * N + (acc % w)) : AW'(acc);
        rdw_exp = model_rd(rdw_addr);
        rd_en = NR'(1);
        rd_addr[0 +: AW] = rdw_addr;
      end
      tick();
      ld_start = 1'b0;
      ld_sel = sel;
      if (rdw) begin
        rd_en = '0;
        check($sformatf("%s rdw old @%h", tag, rdw_addr), rd_data[0 +: DW], rdw_exp);
        last_rd[0] = rdw_exp;
      end
      if (ld_valid) begin
        if (sel) ker_m[acc / K][acc % K] = d;
        else     img_m[acc] = d;
        acc++;
      end
      ld_valid = 1'b0;
      if (abort_after > 0 && acc == abort_after) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        $display("[TB] load %s bank=%0d aborted after %0d beats", tag, sel, acc);
        return;
      end
      if (acc < total) begin
        check($sformatf("%s ld_ready beat %0d", tag, acc), ld_ready, 1);
        check($sformatf("%s ld_done beat %0d", tag, acc), ld_done, 0);
      end
    end
    if (sel) ker_f = 1; else img_f = 1;
    $display("[TB] load %s bank=%0d beats=%0d cycles=%0d", tag, sel, acc, cyc);
    check({tag, " ld_done pulse"}, ld_done, 1);
    check({tag, " ld_ready drop"}, ld_ready, 0);
    check({tag, " img_loaded"}, img_loaded, img_f);
    check({tag, " ker_loaded"}, ker_loaded, ker_f);
    check({tag, " operands_ready"}, operands_ready, img_f & ker_f);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ld_ready"}, ld_ready, 0);
    check({tag, " ld_done"}, ld_done, 0);
    check({tag, " img_loaded"}, img_loaded, 0);
    check({tag, " ker_loaded"}, ker_loaded, 0);
    check({tag, " operands_ready"}, operands_ready, 0);
    check({tag, " rd_valid"}, rd_valid, 0);
    check({tag, " rd_data"}, rd_data, 0);
  endtask

  task automatic b_load(input bit sel);
    int total, w;
    logic [B_DW-1:0] d;
    w = sel ? B_K : B_N;
    total = w * w;
    b_ld_start = 1'b1;
    b_ld_sel = sel;
    tick();
    b_ld_start = 1'b0;
    check("B ld_ready after start", b_ld_ready, 1);
    for (int k = 0; k < total; k++) begin
      d = B_DW'($urandom);
      b_ld_valid = 1'b1;
      b_ld_data = d;
      tick();
      if (sel) b_ker_m[k / B_K][k % B_K] = d;
      else     b_img_m[k] = d;
      if (k < total - 1) check($sformatf("B ld_ready beat %0d", k), b_ld_ready, 1);
    end
    b_ld_valid = 1'b0;
    if (sel) b_ker_f = 1; else b_img_f = 1;
    $display("[TB] load B bank=%0d beats=%0d", sel, total);
    check("B ld_done", b_ld_done, 1);
    check("B ld_ready drop", b_ld_ready, 0);
    check("B flag", sel ? b_ker_loaded : b_img_loaded, 1);
    check("B operands_ready", b_operands_ready, b_img_f & b_ker_f);
  endtask

  task automatic b_read(input logic [B_AW-1:0] addr);
    logic [B_DW-1:0] exp;
    exp = b_model_rd(addr);
    b_rd_en = 1'b1;
    b_rd_addr = addr;
    tick();
    b_rd_en = 1'b0;
    $display("[TB] read B addr=%h data=%h", addr, b_rd_data);
    check($sformatf("B rd_data @%h", addr), b_rd_data, exp);
    check($sformatf("B rd_valid @%h", addr), b_rd_valid, 1);
  endtask

  initial begin
    rst = 1'b1; ld_start = 0; ld_sel = 0; ld_valid = 0; ld_data = '0; rd_en = '0; rd_addr = '0;
    b_rst = 1'b1; b_ld_start = 0; b_ld_sel = 0; b_ld_valid = 0; b_ld_data = '0;
    b_rd_en = '0; b_rd_addr = '0;
    for (int i = 0; i < B_N*B_N; i++) b_img_m[i] = '0;
    for (int r = 0; r < B_K; r++) for (int c = 0; c < B_K; c++) b_ker_m[r][c] = '0;
    b_img_f = 0;
    b_ker_f = 0;
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    b_rst = 1'b0;

    check_reset_state("reset");
    check("B reset rd_valid", b_rd_valid, 0);
    check("B reset ld_ready", b_ld_ready, 0);
    do_reads('1, AW'(0), AW'(5'h10), AW'(0), "after reset");
    do_reads('0, AW'(3), AW'(3), AW'(3), "disabled");

    do_load(1'b0, 1'b1, 1, 3, 1'b0, 1'b0, 0, "img seq");
    do_reads('1, AW'(6), AW'(6), AW'(6), "img idx6");
    check("img idx6 literal", rd_data[0 +: DW], 7);

    do_load(1'b1, 1'b1, 8'h11, 0, 1'b0, 1'b0, 0, "ker seq");
    do_reads('1, AW'(5'h15), AW'(5'h13), AW'(5'h1C), "ker zero-fill");
    check("ker row1 col1 literal", rd_data[0 +: DW], 8'h15);
    do_reads('1, AW'(5'h00), AW'(5'h0F), AW'(5'h12), "parallel");
    check("parallel port2 literal", rd_data[2*DW +: DW], 8'h13);
    random_reads(25, "rand1");

    do_load(1'b0, 1'b0, 0, 1, 1'b1, 1'b0, 0, "img reload rdw");
    do_load(1'b1, 1'b0, 0, 1, 1'b1, 1'b1, 0, "ker reload rdw");
    random_reads(20, "rand2");

    do_load(1'b0, 1'b0, 0, 1, 1'b0, 1'b1, 5, "img abort");
    check_reset_state("after abort");
    random_reads(10, "post-abort");

    do_load(1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 0, "img full");
    do_load(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, "ker full");
    random_reads(20, "rand3");

    b_load(1'b0);
    b_load(1'b1);
    for (int a = 0; a < (1 << B_AW); a++) b_read(B_AW'(a));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
